// File: rtl/restor_div_pkg.sv
// ============================================================================
// Package     : restor_div_pkg
// Description : Shared sizing constants and FSM state type for the
//               restoring-division reconstruction (shift-add MAC) block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package restor_div_pkg;

    localparam int WIDTH         = 16;
    localparam int COUNTER_WIDTH = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } recon_state_t;

endpackage : restor_div_pkg

`default_nettype wire

// File: rtl/mult_step_counter.sv
// ============================================================================
// Module      : mult_step_counter
// Description : Iteration counter for the shift-add multiplier; flags the
//               final step so the FSM leaves CALC after exactly WIDTH steps.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_step_counter #(
    parameter int WIDTH         = restor_div_pkg::WIDTH,
    parameter int COUNTER_WIDTH = restor_div_pkg::COUNTER_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic en,
    output logic last
);

    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic [COUNTER_WIDTH-1:0] cnt_d;

    // start wins over en so a fresh operand set always begins at step 0
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == COUNTER_WIDTH'(WIDTH - 1));

endmodule : mult_step_counter

`default_nettype wire

// File: rtl/restoring_division_reconstruct.sv
// ============================================================================
// Module      : restoring_division_reconstruct
// Description : Sequential shift-add MAC rebuilding dividend = q*d + r from a
//               divider result, with zero-divisor and remainder-range flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_division_reconstruct #(
    parameter int WIDTH         = restor_div_pkg::WIDTH,
    parameter int COUNTER_WIDTH = restor_div_pkg::COUNTER_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [WIDTH-1:0]     quotient,
    input  logic [WIDTH-1:0]     divisor,
    input  logic [WIDTH-1:0]     remainder,
    output logic                 dst_valid,
    input  logic                 dst_ready,
    output logic [2*WIDTH-1:0]   dividend,
    output logic                 div_zero,
    output logic                 rem_ge_div
);

    import restor_div_pkg::*;

    recon_state_t state_q, state_d;

    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     r_q, r_d;
    logic [2*WIDTH-1:0]   dividend_q, dividend_d;
    logic                 div_zero_q, div_zero_d;
    logic                 rem_ge_div_q, rem_ge_div_d;

    logic                 accept;
    logic                 cnt_en;
    logic                 cnt_last;
    logic [WIDTH:0]       step_sum;

    mult_step_counter #(
        .WIDTH         (WIDTH),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_step_counter (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .en    (cnt_en),
        .last  (cnt_last)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (src_valid)  state_d = CALC;
            CALC:    if (cnt_last)   state_d = ADD;
            ADD:                     state_d = DONE;
            DONE:    if (dst_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        src_ready = (state_q == IDLE);
        dst_valid = (state_q == DONE);
        accept    = (state_q == IDLE) && src_valid;
        cnt_en    = (state_q == CALC);
    end

    // ---------------- Datapath ----------------
    // A keeps one spare bit so the carry of A+M survives into the shift.
    always_comb begin
        a_d          = a_q;
        m_d          = m_q;
        q_d          = q_q;
        r_d          = r_q;
        dividend_d   = dividend_q;
        div_zero_d   = div_zero_q;
        rem_ge_div_d = rem_ge_div_q;
        step_sum     = a_q + {1'b0, (q_q[0] ? m_q : {WIDTH{1'b0}})};

        if (accept) begin
            m_d          = divisor;
            q_d          = quotient;
            a_d          = '0;
            r_d          = remainder;
            div_zero_d   = (divisor == '0);
            rem_ge_div_d = (remainder >= divisor);
        end else if (state_q == CALC) begin
            a_d = {1'b0, step_sum[WIDTH:1]};
            q_d = {step_sum[0], q_q[WIDTH-1:1]};
        end else if (state_q == ADD) begin
            dividend_d = {a_q[WIDTH-1:0], q_q} + {{WIDTH{1'b0}}, r_q};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= '0;
            m_q          <= '0;
            q_q          <= '0;
            r_q          <= '0;
            dividend_q   <= '0;
            div_zero_q   <= 1'b0;
            rem_ge_div_q <= 1'b0;
        end else begin
            a_q          <= a_d;
            m_q          <= m_d;
            q_q          <= q_d;
            r_q          <= r_d;
            dividend_q   <= dividend_d;
            div_zero_q   <= div_zero_d;
            rem_ge_div_q <= rem_ge_div_d;
        end
    end

    assign dividend   = dividend_q;
    assign div_zero   = div_zero_q;
    assign rem_ge_div = rem_ge_div_q;

endmodule : restoring_division_reconstruct

`default_nettype wire

// File: tb/tb_restoring_division_reconstruct.sv
// ============================================================================
// Module      : tb_restoring_division_reconstruct
// Description : Self-checking bench: cycle-level behavioural model plus
//               directed vectors for the reconstruction MAC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_restoring_division_reconstruct;

    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            src_valid;
    logic            src_ready;
    logic [W-1:0]    quotient;
    logic [W-1:0]    divisor;
    logic [W-1:0]    remainder;
    logic            dst_valid;
    logic            dst_ready;
    logic [2*W-1:0]  dividend;
    logic            div_zero;
    logic            rem_ge_div;

    int cmp_count  = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    restoring_division_reconstruct dut (
        .clk        (clk),
        .reset      (reset),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .quotient   (quotient),
        .divisor    (divisor),
        .remainder  (remainder),
        .dst_valid  (dst_valid),
        .dst_ready  (dst_ready),
        .dividend   (dividend),
        .div_zero   (div_zero),
        .rem_ge_div (rem_ge_div)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        cmp_count++;
        fail_count++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Behavioural model: busy from accept until the result is taken,
    // result visible LAT edges after accept, plain arithmetic for the value.
    bit          m_started = 0;
    bit          m_busy    = 0;
    int          m_cnt     = 0;
    logic [31:0] m_pend    = '0;
    logic [31:0] m_div     = '0;
    bit          m_dz      = 0;
    bit          m_rge     = 0;
    int          cyc       = 0;

    always @(posedge clk) begin
        cyc++;
        m_started = 1;
        if (reset) begin
            m_busy = 0;
            m_cnt  = 0;
            m_div  = '0;
            m_dz   = 0;
            m_rge  = 0;
        end else if (!m_busy) begin
            if (src_valid) begin
                m_busy = 1;
                m_cnt  = 0;
                m_pend = 32'(quotient) * 32'(divisor) + 32'(remainder);
                m_dz   = (divisor == 0);
                m_rge  = (remainder >= divisor);
            end
        end else if (m_cnt < LAT) begin
            m_cnt++;
            if (m_cnt == LAT) m_div = m_pend;
        end else if (dst_ready) begin
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("src_ready",  64'(src_ready),  64'(!m_busy));
            chk("dst_valid",  64'(dst_valid),  64'(m_busy && m_cnt == LAT));
            chk("dividend",   64'(dividend),   64'(m_div));
            chk("div_zero",   64'(div_zero),   64'(m_dz));
            chk("rem_ge_div", 64'(rem_ge_div), 64'(m_rge));
        end
    end

    task automatic wait_ready();
        int g = 0;
        @(negedge clk);
        while (!src_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!src_ready) timeout("wait_src_ready");
    endtask

    task automatic do_op(input logic [W-1:0] q, input logic [W-1:0] d,
                         input logic [W-1:0] r, output int lat);
        wait_ready();
        src_valid = 1'b1;
        quotient  = q;
        divisor   = d;
        remainder = r;
        @(posedge clk);
        #1 src_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!dst_valid && lat < 100);
        if (!dst_valid) timeout("wait_dst_valid");
    endtask

    task automatic finish_op();
        dst_ready = 1'b1;
        @(posedge clk);
        #1 dst_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int last_ready;
        int accepts;
        int budget;

        reset     = 1'b1;
        src_valid = 1'b0;
        dst_ready = 1'b0;
        quotient  = '0;
        divisor   = '0;
        remainder = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_src_ready", 64'(src_ready), 64'd1);
        chk("rst_dst_valid", 64'(dst_valid), 64'd0);
        chk("rst_dividend",  64'(dividend),  64'd0);

        // 1: small values, latency pinned
        do_op(16'h0003, 16'h0005, 16'h0002, lat);
        chk("t1_latency",  64'(lat),        64'd17);
        chk("t1_dividend", 64'(dividend),   64'h0000_0011);
        chk("t1_div_zero", 64'(div_zero),   64'd0);
        chk("t1_rem_ge",   64'(rem_ge_div), 64'd0);
        finish_op();

        // 2: all ones, carries through A[width]
        do_op(16'hFFFF, 16'hFFFF, 16'hFFFF, lat);
        chk("t2_dividend", 64'(dividend),   64'hFFFF_0000);
        chk("t2_div_zero", 64'(div_zero),   64'd0);
        chk("t2_rem_ge",   64'(rem_ge_div), 64'd1);
        finish_op();

        // 3: zero divisor
        do_op(16'h1234, 16'h0000, 16'h0042, lat);
        chk("t3_dividend", 64'(dividend),   64'h0000_0042);
        chk("t3_div_zero", 64'(div_zero),   64'd1);
        chk("t3_rem_ge",   64'(rem_ge_div), 64'd1);
        finish_op();

        // 4: stall in DONE while inputs churn
        do_op(16'h00AB, 16'h0010, 16'h0003, lat);
        for (int i = 0; i < 5; i++) begin
            src_valid = ~src_valid;
            quotient  = 16'($urandom);
            divisor   = 16'($urandom);
            remainder = 16'($urandom);
            @(posedge clk);
            #1;
            chk("t4_src_ready", 64'(src_ready), 64'd0);
            chk("t4_dst_valid", 64'(dst_valid), 64'd1);
            chk("t4_dividend",  64'(dividend),  64'h0000_0AB3);
        end
        src_valid = 1'b0;
        finish_op();

        // 5: reset in the middle of CALC
        wait_ready();
        src_valid = 1'b1;
        quotient  = 16'h7777;
        divisor   = 16'h0003;
        remainder = 16'h0001;
        @(posedge clk);
        #1 src_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("t5_src_ready", 64'(src_ready), 64'd1);
        chk("t5_dst_valid", 64'(dst_valid), 64'd0);
        chk("t5_dividend",  64'(dividend),  64'd0);
        do_op(16'h0100, 16'h0100, 16'h0000, lat);
        chk("t5_dividend2", 64'(dividend),  64'h0001_0000);
        finish_op();

        // 6: back-to-back legal operands, both handshakes always asserted
        src_valid  = 1'b1;
        dst_ready  = 1'b1;
        last_ready = -1;
        accepts    = 0;
        budget     = 0;
        while (accepts < 6 && budget < 400) begin
            @(negedge clk);
            budget++;
            if (src_ready) begin
                if (last_ready >= 0) chk("t6_period", 64'(cyc - last_ready), 64'd19);
                last_ready = cyc;
                accepts++;
                divisor   = 16'($urandom_range(65535, 1));
                remainder = 16'($urandom_range(int'(divisor) - 1, 0));
                quotient  = 16'($urandom);
            end
        end
        if (accepts < 6) timeout("t6_accepts");
        @(posedge clk);
        #1 src_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1 dst_ready = 1'b0;
        chk("t6_idle", 64'(src_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule : tb_restoring_division_reconstruct

`default_nettype wire
